ruler_search_controller: RTL and testbench
==========================================

RULER_SEARCH_CONTROLLER -- requirements
Module: ruler_search_controller

Interface
REQ-001 SHALL have parameter NUMPOSITIONS, default 5: index of the leaf mark; marks m[0..NUMPOSITIONS].
REQ-002 SHALL have parameter MAXVALUE, default 500: largest legal limit value.
REQ-003 SHALL have port clock  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a search; sampled only in IDLE.
REQ-006 SHALL have port abort  in  1  forces return to IDLE from any state; best result is kept.
REQ-007 SHALL have port init_limit  in  9  initial upper bound for the leaf mark.
REQ-008 SHALL have port counter_reset  out  1  synchronous reset pulse to all mark counters.
REQ-009 SHALL have port resetvalue  out  9  value loaded by the counters on counter_reset; constant 0.
REQ-010 SHALL have port enabled  out  7  level of the single active mark counter.
REQ-011 SHALL have port limit  out  9  current bound; leaf value must not exceed it.
REQ-012 SHALL have port ready_in  in  1  counters' result valid.
REQ-013 SHALL have port nextEnabled_in  in  7  active counter's choice of next level.
REQ-014 SHALL have port success_in  in  1  leaf reports a valid ruler.
REQ-015 SHALL have port marks_in  in  (NUMPOSITIONS+1)*9  concatenated marks, m[0] most significant.
REQ-016 SHALL have port best_marks  out  (NUMPOSITIONS+1)*9  last ruler found.
REQ-017 SHALL have port best_valid  out  1  best_marks holds a found ruler.
REQ-018 SHALL have port found_count  out  16  rulers found, saturating at 16'hFFFF.
REQ-019 SHALL have ports busy, done, error  out  1 each  status flags.

Function
REQ-020 SHALL implement states IDLE, CLEAR, ISSUE, COLLECT, DONE, ERROR.
REQ-021 In IDLE, start=1 SHALL:
  - load limit=init_limit, clamped to MAXVALUE
  - set enabled=1
  - clear best_valid, found_count, done and error
  - go to CLEAR.
REQ-022 CLEAR SHALL assert counter_reset for exactly one cycle, then go to ISSUE; busy=1 from CLEAR until DONE, ERROR or IDLE.
REQ-023 ISSUE SHALL hold enabled stable for one cycle, during which the counters step, then go to COLLECT.
REQ-024 COLLECT SHALL stay while ready_in=0, holding enabled, limit and best_* unchanged; there is no timeout.
REQ-025 COLLECT with ready_in=1 SHALL sample nextEnabled_in, success_in and marks_in in the same cycle.
REQ-026 When success_in=1 and enabled==NUMPOSITIONS, the controller SHALL:
  - latch marks_in into best_marks
  - set best_valid=1
  - increment found_count
  - set limit = leaf mark - 1, where the leaf mark is the least-significant 9 bits of marks_in.
REQ-027 success_in=1 when enabled!=NUMPOSITIONS SHALL be ignored.
REQ-028 If success and nextEnabled_in arrive in the same sample, both SHALL take effect.
REQ-029 The limit update SHALL be visible in the ISSUE cycle that follows.
REQ-030 If the leaf mark is 0 when success is sampled, limit SHALL become 0; no underflow wrap.
REQ-031 nextEnabled_in == 0 SHALL go to DONE with done=1 and busy=0; the search space is exhausted.
REQ-032 nextEnabled_in in 1..NUMPOSITIONS SHALL set enabled=nextEnabled_in and go to ISSUE.
REQ-033 nextEnabled_in > NUMPOSITIONS SHALL go to ERROR with error=1 and enabled=0.
REQ-034 DONE and ERROR SHALL hold until abort=1 or start=1.
REQ-035 start=1 in DONE or ERROR SHALL behave as in IDLE.
REQ-036 start while busy=1 SHALL be ignored.
REQ-037 abort SHALL take priority over start and over any sample in the same cycle.
REQ-038 abort SHALL set enabled=0 and busy=0 and return to IDLE next cycle.

Reset
REQ-039 reset=0 SHALL immediately force:
  - state IDLE
  - enabled=0, limit=0, counter_reset=0
  - best_marks=0, best_valid=0, found_count=0
  - busy=0, done=0, error=0.
REQ-040 Reset mid-search SHALL discard all progress; the first rising edge after reset=1 is treated as IDLE.

Verification
REQ-041 Bench: start with init_limit=20 -> counter_reset high exactly one cycle, then enabled=1 in ISSUE, busy=1.
REQ-042 Bench: enabled=5 with ready_in=1, success_in=1, marks {0,1,4,10,12,17}, nextEnabled_in=5 -> best_marks latched, best_valid=1, found_count=1, limit=16, enabled stays 5.
REQ-043 Bench: ready_in held low 10 cycles in COLLECT -> all outputs frozen; sample taken on the first ready_in=1 cycle.
REQ-044 Bench: nextEnabled_in=0 -> done=1, busy=0; nextEnabled_in=7 -> error=1, enabled=0.
REQ-045 Bench: reset driven low mid-COLLECT with found_count=3 -> all outputs zero asynchronously; start after release begins a clean search.
REQ-046 Bench: success_in=1 with enabled=3 -> found_count and limit unchanged.

Source files
------------

// File: rtl/ruler_search_controller.sv
// Sequencing controller for a Golomb-ruler search: walks the active mark level,
// tightens the leaf bound on every ruler found and keeps the most recent one.
module ruler_search_controller #(
  parameter int NUMPOSITIONS = 5,
  parameter int MAXVALUE     = 500
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [8:0]                    init_limit,
  output logic                          counter_reset,
  output logic [8:0]                    resetvalue,
  output logic [6:0]                    enabled,
  output logic [8:0]                    limit,
  input  logic                          ready_in,
  input  logic [6:0]                    nextEnabled_in,
  input  logic                          success_in,
  input  logic [(NUMPOSITIONS+1)*9-1:0] marks_in,
  output logic [(NUMPOSITIONS+1)*9-1:0] best_marks,
  output logic                          best_valid,
  output logic [15:0]                   found_count,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam int              MW      = (NUMPOSITIONS + 1) * 9;
  localparam logic [6:0]      LEAF    = 7'(NUMPOSITIONS);
  localparam logic [8:0]      MAX_LIM = 9'(MAXVALUE);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, COLLECT, DONE, ERROR} state_t;

  state_t          state_q, state_d;
  logic [6:0]      enabled_q, enabled_d;
  logic [8:0]      limit_q, limit_d;
  logic [MW-1:0]   best_marks_q, best_marks_d;
  logic            best_valid_q, best_valid_d;
  logic [15:0]     found_count_q, found_count_d;
  logic [8:0]      leaf_mark;

  assign leaf_mark = marks_in[8:0];

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    enabled_d     = enabled_q;
    limit_d       = limit_q;
    best_marks_d  = best_marks_q;
    best_valid_d  = best_valid_q;
    found_count_d = found_count_q;

    if (abort) begin
      state_d   = IDLE;
      enabled_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_d       = CLEAR;
            limit_d       = (init_limit > MAX_LIM) ? MAX_LIM : init_limit;
            enabled_d     = 7'd1;
            best_valid_d  = 1'b0;
            found_count_d = '0;
          end
        end
        CLEAR:   state_d = ISSUE;
        ISSUE:   state_d = COLLECT;
        COLLECT: begin
          if (ready_in) begin
            // A ruler only counts when the leaf itself reports it.
            if (success_in && (enabled_q == LEAF)) begin
              best_marks_d = marks_in;
              best_valid_d = 1'b1;
              if (found_count_q != 16'hFFFF) found_count_d = found_count_q + 16'd1;
              limit_d = (leaf_mark == 9'd0) ? 9'd0 : leaf_mark - 9'd1;
            end
            if (nextEnabled_in == 7'd0) begin
              state_d = DONE;
            end else if (nextEnabled_in <= LEAF) begin
              state_d   = ISSUE;
              enabled_d = nextEnabled_in;
            end else begin
              state_d   = ERROR;
              enabled_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      enabled_q     <= '0;
      limit_q       <= '0;
      best_marks_q  <= '0;
      best_valid_q  <= 1'b0;
      found_count_q <= '0;
    end else begin
      state_q       <= state_d;
      enabled_q     <= enabled_d;
      limit_q       <= limit_d;
      best_marks_q  <= best_marks_d;
      best_valid_q  <= best_valid_d;
      found_count_q <= found_count_d;
    end
  end

  // Status flags decode straight from the state so reset clears them without a clock.
  assign counter_reset = (state_q == CLEAR);
  assign busy          = (state_q == CLEAR) || (state_q == ISSUE) || (state_q == COLLECT);
  assign done          = (state_q == DONE);
  assign error         = (state_q == ERROR);
  assign resetvalue    = '0;
  assign enabled       = enabled_q;
  assign limit         = limit_q;
  assign best_marks    = best_marks_q;
  assign best_valid    = best_valid_q;
  assign found_count   = found_count_q;

endmodule

// File: tb/tb_ruler_search_controller.sv
// Directed bench for ruler_search_controller: expected post-edge outputs are
// queued as each step is driven and compared once the edge has happened.
module tb_ruler_search_controller;

  localparam int N  = 5;
  localparam int MW = (N + 1) * 9;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [8:0]    init_limit = '0;
  logic          counter_reset;
  logic [8:0]    resetvalue;
  logic [6:0]    enabled;
  logic [8:0]    limit;
  logic          ready_in = 1'b0;
  logic [6:0]    nextEnabled_in = '0;
  logic          success_in = 1'b0;
  logic [MW-1:0] marks_in = '0;
  logic [MW-1:0] best_marks;
  logic          best_valid;
  logic [15:0]   found_count;
  logic          busy;
  logic          done;
  logic          error;

  ruler_search_controller #(.NUMPOSITIONS(N), .MAXVALUE(500)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .init_limit(init_limit), .counter_reset(counter_reset), .resetvalue(resetvalue),
    .enabled(enabled), .limit(limit), .ready_in(ready_in),
    .nextEnabled_in(nextEnabled_in), .success_in(success_in), .marks_in(marks_in),
    .best_marks(best_marks), .best_valid(best_valid), .found_count(found_count),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0]  en;
    logic [8:0]  lim;
    logic [15:0] cnt;
    logic        valid;
    logic        bsy;
    logic        dn;
    logic        err;
    logic        cr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [MW-1:0] M1 = {9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd17};
  localparam logic [MW-1:0] M2 = {9'd0, 9'd2, 9'd5, 9'd8, 9'd11, 9'd15};
  localparam logic [MW-1:0] M3 = {9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5};
  localparam logic [MW-1:0] M4 = {9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int en, input int lim, input int cnt, input bit valid,
                              input bit bsy, input bit dn, input bit err, input bit cr);
    exp_t e;
    e.en = 7'(en); e.lim = 9'(lim); e.cnt = 16'(cnt);
    e.valid = valid; e.bsy = bsy; e.dn = dn; e.err = err; e.cr = cr;
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".enabled"},       64'(enabled),       64'(e.en));
      check({tag, ".limit"},         64'(limit),         64'(e.lim));
      check({tag, ".found_count"},   64'(found_count),   64'(e.cnt));
      check({tag, ".best_valid"},    64'(best_valid),    64'(e.valid));
      check({tag, ".busy"},          64'(busy),          64'(e.bsy));
      check({tag, ".done"},          64'(done),          64'(e.dn));
      check({tag, ".error"},         64'(error),         64'(e.err));
      check({tag, ".counter_reset"}, 64'(counter_reset), 64'(e.cr));
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_step(input string tag, input exp_t e);
    sb.push_back(e);
    step();
    pop_check(tag);
  endtask

  initial begin
    // Reset is low from time zero: everything must read zero without a clock edge.
    #2;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    pop_check("por");
    check("por.best_marks", 64'(best_marks), 64'd0);
    check("por.resetvalue", 64'(resetvalue), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Start a search: CLEAR pulses counter_reset once, ISSUE holds enabled=1.
    start = 1'b1; init_limit = 9'd20;
    expect_step("clear", mk(1, 20, 0, 0, 1, 0, 0, 1));
    start = 1'b0;
    expect_step("issue", mk(1, 20, 0, 0, 1, 0, 0, 0));
    expect_step("collect", mk(1, 20, 0, 0, 1, 0, 0, 0));

    // Jump straight to the leaf level.
    ready_in = 1'b1; nextEnabled_in = 7'd5;
    expect_step("to_leaf", mk(5, 20, 0, 0, 1, 0, 0, 0));
    ready_in = 1'b0;
    expect_step("to_leaf.collect", mk(5, 20, 0, 0, 1, 0, 0, 0));

    // Leaf success and a same-level next choice land together.
    ready_in = 1'b1; success_in = 1'b1; marks_in = M1; nextEnabled_in = 7'd5;
    expect_step("found1", mk(5, 16, 1, 1, 1, 0, 0, 0));
    check("found1.best_marks", 64'(best_marks), 64'(M1));
    ready_in = 1'b0;
    expect_step("found1.collect", mk(5, 16, 1, 1, 1, 0, 0, 0));

    // Stall: inputs that would change everything are present but never sampled.
    marks_in = '1; nextEnabled_in = 7'd0;
    for (int i = 0; i < 10; i++) expect_step("stall", mk(5, 16, 1, 1, 1, 0, 0, 0));
    check("stall.best_marks", 64'(best_marks), 64'(M1));
    ready_in = 1'b1; marks_in = M2; nextEnabled_in = 7'd3;
    expect_step("found2", mk(3, 14, 2, 1, 1, 0, 0, 0));
    check("found2.best_marks", 64'(best_marks), 64'(M2));
    ready_in = 1'b0;
    expect_step("found2.collect", mk(3, 14, 2, 1, 1, 0, 0, 0));

    // Success from a non-leaf level is ignored.
    ready_in = 1'b1; marks_in = M3; nextEnabled_in = 7'd5;
    expect_step("nonleaf", mk(5, 14, 2, 1, 1, 0, 0, 0));
    check("nonleaf.best_marks", 64'(best_marks), 64'(M2));
    ready_in = 1'b0;
    expect_step("nonleaf.collect", mk(5, 14, 2, 1, 1, 0, 0, 0));

    // Leaf mark of zero clamps the bound at zero.
    ready_in = 1'b1; marks_in = M4;
    expect_step("leaf0", mk(5, 0, 3, 1, 1, 0, 0, 0));
    ready_in = 1'b0; success_in = 1'b0;
    expect_step("leaf0.collect", mk(5, 0, 3, 1, 1, 0, 0, 0));

    // Asynchronous reset in the middle of COLLECT.
    #2 reset = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    pop_check("midreset");
    check("midreset.best_marks", 64'(best_marks), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Clean restart with an over-range limit, then exhaust the search.
    start = 1'b1; init_limit = 9'd511;
    expect_step("clamp", mk(1, 500, 0, 0, 1, 0, 0, 1));
    start = 1'b0;
    expect_step("clamp.issue", mk(1, 500, 0, 0, 1, 0, 0, 0));
    expect_step("clamp.collect", mk(1, 500, 0, 0, 1, 0, 0, 0));
    ready_in = 1'b1; nextEnabled_in = 7'd0;
    expect_step("done", mk(1, 500, 0, 0, 0, 1, 0, 0));
    ready_in = 1'b0;
    expect_step("done.hold", mk(1, 500, 0, 0, 0, 1, 0, 0));

    // Restart from DONE; a start while busy is ignored.
    start = 1'b1; init_limit = 9'd30;
    expect_step("restart", mk(1, 30, 0, 0, 1, 0, 0, 1));
    start = 1'b0;
    expect_step("restart.issue", mk(1, 30, 0, 0, 1, 0, 0, 0));
    expect_step("restart.collect", mk(1, 30, 0, 0, 1, 0, 0, 0));
    start = 1'b1;
    expect_step("busy_start", mk(1, 30, 0, 0, 1, 0, 0, 0));
    start = 1'b0;

    // Illegal next level.
    ready_in = 1'b1; nextEnabled_in = 7'd7;
    expect_step("error", mk(0, 30, 0, 0, 0, 0, 1, 0));
    ready_in = 1'b0;
    expect_step("error.hold", mk(0, 30, 0, 0, 0, 0, 1, 0));

    // Abort beats a simultaneous start.
    abort = 1'b1; start = 1'b1; init_limit = 9'd40;
    expect_step("abort_err", mk(0, 30, 0, 0, 0, 0, 0, 0));
    abort = 1'b0; start = 1'b0;

    // Abort beats a simultaneous sample in COLLECT.
    start = 1'b1;
    expect_step("s3.clear", mk(1, 40, 0, 0, 1, 0, 0, 1));
    start = 1'b0;
    expect_step("s3.issue", mk(1, 40, 0, 0, 1, 0, 0, 0));
    expect_step("s3.collect", mk(1, 40, 0, 0, 1, 0, 0, 0));
    abort = 1'b1; ready_in = 1'b1; nextEnabled_in = 7'd2;
    expect_step("abort_sample", mk(0, 40, 0, 0, 0, 0, 0, 0));
    abort = 1'b0; ready_in = 1'b0;
    expect_step("idle.hold", mk(0, 40, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
